// File: rtl/led_pwm_driver.sv
// led_pwm_driver: three-channel PWM LED driver with linear fades between colours.
//
// A free-running counter sets the PWM period (2^PWM_BITS cycles). Each channel
// has a level register that moves toward its target by at most FADE_STEP per
// period. The target is brightness when the channel's colour bit is set and
// enable is high, otherwise 0. Levels change only on the edge that leaves
// cnt = MAX, so a PWM period never changes duty part-way through.
//
// Ports:
//   clk          - rising-edge clock
//   rst          - synchronous active-high reset
//   colour       - colour code: bit 2 red, bit 1 green, bit 0 blue
//   enable       - 1 shows the colour, 0 drives every target to 0
//   brightness   - on-level applied to every channel whose colour bit is set
//   led_r/g/b    - registered PWM outputs, high while cnt < level
//   period_start - registered pulse in each cycle where cnt = 0 (not the first
//                  cycle after reset)

module led_pwm_driver #(
  parameter int unsigned PWM_BITS  = 8,
  parameter int unsigned FADE_STEP = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          colour,
  input  logic                enable,
  input  logic [PWM_BITS-1:0] brightness,
  output logic                led_r,
  output logic                led_g,
  output logic                led_b,
  output logic                period_start
);

  localparam int unsigned LW = PWM_BITS;
  // One guard bit so level +/- step never wraps.
  localparam int unsigned XW = PWM_BITS + 1;

  localparam logic [LW-1:0] CNT_MAX = {LW{1'b1}};
  localparam logic [XW-1:0] STEP    = XW'(FADE_STEP);

  logic [LW-1:0] cnt;
  logic [LW-1:0] lvl_r;
  logic [LW-1:0] lvl_g;
  logic [LW-1:0] lvl_b;

  logic          boundary_c;
  logic [LW-1:0] tgt_r_c;
  logic [LW-1:0] tgt_g_c;
  logic [LW-1:0] tgt_b_c;
  logic [LW-1:0] lvl_r_nxt_c;
  logic [LW-1:0] lvl_g_nxt_c;
  logic [LW-1:0] lvl_b_nxt_c;

  // One fade step from lvl toward tgt, clamped so the target is never overshot.
  function automatic logic [LW-1:0] fade_step(input logic [LW-1:0] lvl,
                                               input logic [LW-1:0] tgt);
    logic [XW-1:0] l;
    logic [XW-1:0] t;
    logic [XW-1:0] up;
    logic [XW-1:0] gap;
    logic [LW-1:0] res;
    l   = {1'b0, lvl};
    t   = {1'b0, tgt};
    up  = l + STEP;
    gap = '0;
    res = lvl;
    if (FADE_STEP == 0) begin
      res = tgt;
    end else if (l < t) begin
      res = (up >= t) ? tgt : up[LW-1:0];
    end else if (l > t) begin
      // Compare the distance rather than subtracting first, so no underflow.
      gap = l - t;
      res = (gap <= STEP) ? tgt : LW'(l - STEP);
    end
    return res;
  endfunction

  // Last cycle of the period: the only cycle whose inputs are consumed.
  assign boundary_c = (cnt == CNT_MAX);

  // Per-channel targets from the current colour / enable / brightness.
  always_comb begin
    tgt_r_c = '0;
    tgt_g_c = '0;
    tgt_b_c = '0;
    if (enable) begin
      if (colour[2]) tgt_r_c = brightness;
      if (colour[1]) tgt_g_c = brightness;
      if (colour[0]) tgt_b_c = brightness;
    end
  end

  // Candidate next levels; committed only at the period boundary.
  always_comb begin
    lvl_r_nxt_c = fade_step(lvl_r, tgt_r_c);
    lvl_g_nxt_c = fade_step(lvl_g, tgt_g_c);
    lvl_b_nxt_c = fade_step(lvl_b, tgt_b_c);
  end

  // Counter, level registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      lvl_r        <= '0;
      lvl_g        <= '0;
      lvl_b        <= '0;
      led_r        <= 1'b0;
      led_g        <= 1'b0;
      led_b        <= 1'b0;
      period_start <= 1'b0;
    end else begin
      cnt          <= cnt + LW'(1);
      // Outputs use the level in force during this cycle (old level at MAX).
      led_r        <= (cnt < lvl_r);
      led_g        <= (cnt < lvl_g);
      led_b        <= (cnt < lvl_b);
      period_start <= boundary_c;
      if (boundary_c) begin
        lvl_r <= lvl_r_nxt_c;
        lvl_g <= lvl_g_nxt_c;
        lvl_b <= lvl_b_nxt_c;
      end
    end
  end

endmodule

// File: tb/tb_led_pwm_driver.sv
// tb_led_pwm_driver: directed bench for led_pwm_driver with PWM_BITS = 4.
// Three instances share clock and reset: FADE_STEP 0 (dut0), 1 (dut1), 4 (dut2).
// Expected per-period high counts come from a small level model and are queued
// when a period's stimulus is applied, then popped when the period completes.

module tb_led_pwm_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] col [3];
  logic       en  [3];
  logic [3:0] br  [3];
  logic       led [9];
  logic       ps  [3];

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int lv[9];

  always #5 clk = ~clk;

  led_pwm_driver #(.PWM_BITS(4), .FADE_STEP(0)) dut0 (
    .clk(clk), .rst(rst), .colour(col[0]), .enable(en[0]), .brightness(br[0]),
    .led_r(led[0]), .led_g(led[1]), .led_b(led[2]), .period_start(ps[0]));

  led_pwm_driver #(.PWM_BITS(4), .FADE_STEP(1)) dut1 (
    .clk(clk), .rst(rst), .colour(col[1]), .enable(en[1]), .brightness(br[1]),
    .led_r(led[3]), .led_g(led[4]), .led_b(led[5]), .period_start(ps[1]));

  led_pwm_driver #(.PWM_BITS(4), .FADE_STEP(4)) dut2 (
    .clk(clk), .rst(rst), .colour(col[2]), .enable(en[2]), .brightness(br[2]),
    .led_r(led[6]), .led_g(led[7]), .led_b(led[8]), .period_start(ps[2]));

  function automatic int fstep(input int k);
    if (k == 0) return 0;
    if (k == 1) return 1;
    return 4;
  endfunction

  // Channel ch: instance ch/3, colour bit 2 - ch%3 (r, g, b).
  function automatic int tgt(input int ch);
    int k;
    int b;
    logic [2:0] c;
    k = ch / 3;
    b = 2 - (ch % 3);
    c = col[k];
    return (en[k] && c[b]) ? int'(br[k]) : 0;
  endfunction

  function automatic int step_lvl(input int l, input int t, input int fs);
    if (fs == 0) return t;
    if (l < t) return (l + fs > t) ? t : l + fs;
    if (l > t) return (l - fs < t) ? t : l - fs;
    return l;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Entered at the negedge of a cnt = 0 cycle; leaves at the next one.
  // Counts highs per channel over the period and checks period_start each cycle.
  task automatic measure(input bit glitch);
    int got[9];
    int nl[9];
    for (int ch = 0; ch < 9; ch++) begin
      exp_q.push_back(lv[ch]);
      got[ch] = 0;
    end
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      for (int ch = 0; ch < 9; ch++) if (led[ch] === 1'b1) got[ch]++;
      for (int k = 0; k < 3; k++)
        check($sformatf("period_start dut%0d cyc%0d", k, i), 32'(ps[k]), (i == 16) ? 1 : 0);
      if (glitch && i == 3) for (int k = 0; k < 3; k++) en[k] = 1'b0;
      if (glitch && i == 9) for (int k = 0; k < 3; k++) en[k] = 1'b1;
    end
    for (int ch = 0; ch < 9; ch++)
      check($sformatf("duty dut%0d ch%0d", ch / 3, ch % 3), got[ch], exp_q.pop_front());
    for (int ch = 0; ch < 9; ch++) nl[ch] = step_lvl(lv[ch], tgt(ch), fstep(ch / 3));
    for (int ch = 0; ch < 9; ch++) lv[ch] = nl[ch];
  endtask

  task automatic check_zero(input string tag);
    for (int ch = 0; ch < 9; ch++) check($sformatf("%s led ch%0d", tag, ch), 32'(led[ch]), 0);
    for (int k = 0; k < 3; k++) check($sformatf("%s period_start dut%0d", tag, k), 32'(ps[k]), 0);
    check({tag, " cnt"}, 32'(dut1.cnt), 0);
    check({tag, " lvl_r"}, 32'(dut1.lvl_r), 0);
    check({tag, " lvl_g"}, 32'(dut1.lvl_g), 0);
    check({tag, " lvl_b"}, 32'(dut1.lvl_b), 0);
    check({tag, " dut2 lvl_b"}, 32'(dut2.lvl_b), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    col[0] = 3'b100; en[0] = 1'b1; br[0] = 4'd5;
    col[1] = 3'b010; en[1] = 1'b1; br[1] = 4'd15;
    col[2] = 3'b111; en[2] = 1'b1; br[2] = 4'd0;
    for (int ch = 0; ch < 9; ch++) lv[ch] = 0;

    // Reset held 3 cycles, outputs all zero.
    repeat (3) begin
      @(negedge clk);
      check_zero("reset");
    end
    rst = 1'b0;

    // First period after release: pulse only on the 16th edge, all duties 0.
    measure(1'b0);

    // Immediate level (dut0) and linear fade up of green (dut1).
    repeat (17) measure(1'b0);

    // Fade green down to 0; dut2 steps 0 -> 10 -> 0 with clamping.
    col[1] = 3'b000;
    br[2]  = 4'd10;
    for (int p = 0; p < 17; p++) begin
      if (p == 4) br[2] = 4'd0;
      measure(1'b0);
    end

    // Boundary-only sampling: a mid-period enable pulse changes nothing.
    br[2] = 4'd12;
    repeat (3) measure(1'b0);
    repeat (2) measure(1'b1);
    for (int k = 0; k < 3; k++) en[k] = 1'b0;
    measure(1'b0);
    for (int k = 0; k < 3; k++) en[k] = 1'b1;
    repeat (2) measure(1'b0);

    // Reset mid-fade at lvl_b = 7, cnt = 6, then fade restarts from 0.
    col[1] = 3'b001;
    br[1]  = 4'd15;
    for (int n = 0; n < 20 && lv[5] != 7; n++) measure(1'b0);
    check("pre-reset lvl_b", 32'(dut1.lvl_b), 7);
    repeat (6) @(negedge clk);
    check("pre-reset cnt", 32'(dut1.cnt), 6);
    rst = 1'b1;
    @(negedge clk);
    check_zero("mid-fade reset");
    rst = 1'b0;
    for (int ch = 0; ch < 9; ch++) lv[ch] = 0;
    repeat (3) measure(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
